// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, LSB-first
// reassembly, with one-cycle rx_done / frame_err strobes.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_n;
    logic                 rx_meta, rx_s;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, dout_n;
    logic                 rx_done_n, frame_err_n;

    // Synchroniser resets high so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            dout      <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            dout      <= dout_n;
            rx_done   <= rx_done_n;
            frame_err <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt + CW'(1);
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        dout_n      = dout;
        rx_done_n   = 1'b0;
        frame_err_n = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end
                end
            end
            DATA: begin
                if (cnt == FULL) begin
                    cnt_n     = '0;
                    shreg_n   = {rx_s, shreg[DATA_BITS-1:1]};
                    bit_idx_n = bit_idx + IW'(1);
                    if (bit_idx == LAST) state_n = STOP;
                end
            end
            STOP: begin
                // Leaving at mid stop bit leaves half a bit to catch the next start edge.
                if (cnt == FULL) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (rx_s) begin
                        dout_n    = shreg;
                        rx_done_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a line driver issues frames and pushes the
// expected strobe into a queue; a negedge monitor pops and compares.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] dout;
    logic       rx_done, frame_err, rx_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // bit 8 set = frame_err expected, else rx_done with dout = bits 7:0
    logic [8:0] exp_q[$];
    int         done_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .dout     (dout),
        .rx_done  (rx_done),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_rng(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, got, lo, hi);
        end
    endtask

    // driver tasks (called at a falling clock edge)
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("drain_pending", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && (rx_done || frame_err)) begin
            if (rx_done) done_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: rx_done=%0b frame_err=%0b dout=0x%0h, required none",
                         rx_done, frame_err, dout);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if (e[8]) begin
                    check("ferr_strobe", {30'd0, frame_err, rx_done}, 32'h2);
                end else begin
                    check("done_strobe", {30'd0, frame_err, rx_done}, 32'h1);
                    check("done_dout", dout, e[7:0]);
                end
            end
        end
    end

    initial begin
        int c0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_dout", dout, 8'h00);
        check("rst_rx_done", rx_done, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_rx_busy", rx_busy, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // single frame 0x8A with latency and busy checks
        done_q.delete();
        exp_q.push_back(9'h08A);
        c0 = cyc;
        fork
            send_frame(8'h8A, 1'b1);
            begin
                repeat (80) @(negedge clk);
                check("busy_mid_frame", rx_busy, 1'b1);
            end
        join
        drain(40);
        check("single_done_count", done_q.size(), 1);
        if (done_q.size() >= 1)
            check_rng("single_latency", done_q[0] - c0, 2 + CPB/2 + 9*CPB - 1, 2 + CPB/2 + 9*CPB + 1);
        check("single_dout", dout, 8'h8A);
        check("idle_busy", rx_busy, 1'b0);

        // back-to-back 0x55, 0xFF, 0x00 with no idle gap
        done_q.delete();
        exp_q.push_back(9'h055);
        exp_q.push_back(9'h0FF);
        exp_q.push_back(9'h000);
        send_frame(8'h55, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        drain(40);
        check("b2b_done_count", done_q.size(), 3);
        if (done_q.size() == 3) begin
            check_rng("b2b_space_1", done_q[1] - done_q[0], 10*CPB - 1, 10*CPB + 1);
            check_rng("b2b_space_2", done_q[2] - done_q[1], 10*CPB - 1, 10*CPB + 1);
        end
        check("b2b_dout", dout, 8'h00);

        // glitch shorter than half a bit is rejected
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("glitch_busy_high", rx_busy, 1'b1);
        repeat (9) @(negedge clk);
        check("glitch_busy_low", rx_busy, 1'b0);
        check("glitch_dout", dout, 8'h00);
        repeat (10) @(negedge clk);

        // good 0xA5, bad-stop 0x3C, then good 0x12
        exp_q.push_back(9'h0A5);
        exp_q.push_back(9'h100);
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b0);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        drain(40);
        check("badstop_dout", dout, 8'hA5);
        exp_q.push_back(9'h012);
        send_frame(8'h12, 1'b1);
        drain(40);
        check("after_bad_dout", dout, 8'h12);

        // break: line held low gives two frame errors, then released mid start bit
        exp_q.push_back(9'h100);
        exp_q.push_back(9'h100);
        rx = 1'b0;
        repeat (311) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        drain(40);
        check("break_dout", dout, 8'h12);
        check("break_busy", rx_busy, 1'b0);

        // reset during data bit 4 of 0x77
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h77 >> i));
        rx = 1'b1;
        repeat (CPB/2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_dout", dout, 8'h00);
        check("midrst_busy", rx_busy, 1'b0);
        check("midrst_strobes", {frame_err, rx_done}, 2'b00);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("postrst_busy", rx_busy, 1'b0);
        exp_q.push_back(9'h0C3);
        send_frame(8'hC3, 1'b1);
        drain(40);
        check("postrst_dout", dout, 8'hC3);

        // transmitter-style stream of 0x8A frames
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(9'h08A);
            send_frame(8'h8A, 1'b1);
        end
        drain(40);
        check("stream_dout", dout, 8'h8A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
